// File: rtl/prio_enc_pkg.sv
// Shared types and sizing helpers for the registered priority encoder family.
// Default request count and index-width helper used by prio_encoder_rr and prio_pick.
package prio_enc_pkg;

    localparam int DEFAULT_N = 4;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEFAULT_W = idx_width(DEFAULT_N);

    typedef logic [DEFAULT_W-1:0] idx_t;

endpackage

// File: rtl/prio_encoder_rr_pick.sv
// prio_pick: combinational search for the first set bit, scanning downward from
// a start index with wrap-around; returns a found flag and the winning index.
module prio_pick
    import prio_enc_pkg::*;
#(
    parameter  int N = DEFAULT_N,
    localparam int W = idx_width(N)
) (
    input  logic [N-1:0] vec,
    input  logic [W-1:0] start,
    output logic         found,
    output logic [W-1:0] idx
);

    logic [W-1:0] pos;

    // Walk from the farthest position to the start so the last hit written is the closest one.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        pos   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            pos = W'((int'(start) + N - k) % N);
            if (vec[pos]) begin
                found = 1'b1;
                idx   = pos;
            end
        end
    end

endmodule

// File: rtl/prio_encoder_rr.sv
// Registered N-to-log2(N) priority encoder with sticky pending bits and a valid/ready output slot.
// Define ROUND_ROBIN_EN to rotate priority after each grant; default build is fixed priority (N-1 highest).
module prio_encoder_rr
    import prio_enc_pkg::*;
#(
    parameter  int N = DEFAULT_N,
    localparam int W = idx_width(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         clr,
    output logic [W-1:0] out_idx,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy
);

    localparam logic [W-1:0] LAST_IDX = W'(N - 1);

    logic [N-1:0] pend_q, pend_d;
    logic [W-1:0] out_idx_q, out_idx_d;
    logic         out_valid_q, out_valid_d;
    logic         busy_q, busy_d;

    logic [W-1:0] start;
    logic         pick_found;
    logic [W-1:0] pick_idx;
    logic         slot_free;
    logic         load;

`ifdef ROUND_ROBIN_EN
    logic [W-1:0] ptr_q, ptr_d;

    assign start = ptr_q;

    // The last winner drops to lowest priority for the next search.
    always_comb begin
        ptr_d = ptr_q;
        if (clr) begin
            ptr_d = LAST_IDX;
        end else if (load) begin
            ptr_d = (pick_idx == '0) ? LAST_IDX : pick_idx - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= LAST_IDX;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    assign start = LAST_IDX;
`endif

    prio_pick #(.N(N)) u_pick (
        .vec   (pend_q),
        .start (start),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign slot_free = !out_valid_q || out_ready;
    assign load      = slot_free && pick_found;

    // clr overrides both the load and any request arriving in the same cycle.
    always_comb begin
        pend_d      = pend_q;
        out_idx_d   = out_idx_q;
        out_valid_d = out_valid_q;
        if (load) begin
            pend_d[pick_idx] = 1'b0;
            out_idx_d        = pick_idx;
        end
        if (slot_free) begin
            out_valid_d = pick_found;
        end
        pend_d = pend_d | req;
        if (clr) begin
            pend_d      = '0;
            out_valid_d = 1'b0;
        end
        busy_d = |pend_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q      <= '0;
            out_idx_q   <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            pend_q      <= pend_d;
            out_idx_q   <= out_idx_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign out_idx   = out_idx_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;

endmodule

// File: doc/prio_encoder_rr.md
# prio_encoder_rr

Parametrised, registered N-to-log2(N) priority encoder; next generation of the team's 4-to-2 encoder. Request bits are captured into a sticky pending register. The block then issues one encoded index per cycle through a valid/ready output handshake, clearing each bit as it is issued. It sits between interrupt/event sources and a single consumer, for example a controller that services one source at a time.

## Interface
- N, default 4: number of request lines; legal range 2..64.
- W, derived, equal to ceil(log2(N)), localparam: index width.
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset; asynchronous assert, active-low, synchronous deassert by the system.
- req  input  N  request pulses or levels; bit i set in a cycle marks source i pending.
- clr  input  1  synchronous flush of all pending state and of the output slot.
- out_idx  output  W  encoded index of the issued source.
- out_valid  output  1  out_idx holds an unconsumed grant.
- out_ready  input  1  consumer accepts out_idx when out_valid and out_ready are both high.
- busy  output  1  OR of all pending bits; excludes the bit held in the output slot.

## Operation
- State:
  - pend[N-1:0]: pending bits.
  - out slot: out_idx and out_valid.
  - ptr[W-1:0]: round-robin pointer, present only with the macro.
- Reset values: pend = 0, out_idx = 0, out_valid = 0, busy = 0, ptr = N-1.
- Slot free condition: !out_valid, or out_valid && out_ready.
- Load: when the slot is free and pend is non-zero, the selected index g is written to out_idx, out_valid is set, and pend[g] is cleared.
- Slot free and pend zero: out_valid clears; out_idx holds its last value.
- pend next value: (pend with the loaded bit cleared) OR req.
  - A req bit asserted in the same cycle its bit is loaded re-arms it, counting as a new event.
  - Repeated req on a bit that is already pending merges into a single event; there is no counting and no overflow.
- Fixed-priority selection: the highest set index wins, so bit N-1 has highest priority (the same ordering as the 4-to-2 encoder).
- clr: pend becomes 0 and out_valid becomes 0 in the next cycle; req in the same cycle is discarded. clr has priority over load and over req.
- Output stability: while out_valid && !out_ready, out_idx is held stable; pend keeps accumulating.
- Reset mid-operation: all state returns to the reset values immediately; grants in flight are lost.
- Not supported: N that is not a power of two with padding indices. Indices >= N are never produced.

## Timing
- Latency: req at edge k sets pend at k; the earliest out_valid with that index is after edge k+1. Two-edge latency, no combinational path from req to outputs.
- Throughput: one grant per cycle while out_ready is held high and pend is non-zero.
- out_ready is sampled only at the rising edge; out_valid never drops without an accept, clr, or reset.
- busy is registered, derived from pend; it lags req by one edge.

## Configuration
- ROUND_ROBIN_EN defined:
  - After each load of g, ptr becomes (g-1) mod N.
  - The search starts at ptr and descends with wrap-around, so the most recent winner becomes lowest priority.
  - clr also resets ptr to N-1.
- ROUND_ROBIN_EN undefined: fixed priority, with N-1 highest. No ptr register exists.
- In both modes the first grant after reset is identical, because ptr resets to N-1.

## Structure
- Package prio_enc_pkg holds:
  - localparam function for index width (clog2 wrapper);
  - typedef for the index type;
  - the default N.
- Sub-module prio_pick: combinational; inputs are a vector and a start pointer, outputs are the found flag and the index. It scans descending from the start with wrap. Fixed mode ties start to N-1.
- Top level holds pend, the out slot, ptr, and the clr/reset logic.

## Test plan
- Reset, N=4:
  - Hold rst_n low, drive req=4'b1111 → out_valid=0, out_idx=0, busy=0 throughout reset.
  - First grant appears two edges after release.
- Fixed priority, N=4, out_ready=1:
  - Single-cycle req=4'b1010 → grants out_idx=3 then 1 on consecutive cycles, then out_valid=0, busy=0.
- Backpressure:
  - Pulse req=4'b0001, hold out_ready=0 for 5 cycles → out_valid=1 and out_idx=0 stable for 5 cycles.
  - A req=4'b0100 pulse during that stall → busy=1.
  - Then raise out_ready → out_idx sequence 0, 2.
- Re-arm:
  - Assert req[2] in the exact cycle bit 2 is loaded → a second grant of idx 2 follows.
  - Repeated req[2] while bit 2 is already pending → only one extra grant.
- clr:
  - With pend=4'b1110 and out_valid=1, pulse clr together with req=4'b0001 → next cycle out_valid=0, busy=0, and no grants follow.
- ROUND_ROBIN_EN, N=4:
  - Hold req=4'b1111 with out_ready=1 → out_idx sequence 3, 2, 1, 0, 3, 2, ...
  - Without the macro, the same stimulus → constant 3.
